// File: rtl/rv32e_dmem_responder_if.sv
// rv32e_dmem_responder_if: data-memory bus between the core (master) and the
// dmem responder (slave).
//   dmem_addr         byte address from core
//   dmem_data_out     lane-aligned write data from core
//   dmem_read         read request
//   dmem_write        write request
//   dmem_byte_enable  lane enables
//   dmem_data_in      full aligned read word back to core
//   dmem_ready        one-cycle completion pulse
//   dmem_error        qualifies dmem_ready: access rejected
interface rv32e_dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_out;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_data_in;
  logic        dmem_ready;
  logic        dmem_error;

  modport master (
    output dmem_addr, dmem_data_out, dmem_read, dmem_write, dmem_byte_enable,
    input  dmem_data_in, dmem_ready, dmem_error
  );

  modport slave (
    input  dmem_addr, dmem_data_out, dmem_read, dmem_write, dmem_byte_enable,
    output dmem_data_in, dmem_ready, dmem_error
  );
endinterface

// File: rtl/rv32e_dmem_responder.sv
// rv32e_dmem_responder: byte-enabled word RAM slave for the core's data port,
// with registered read data and WAIT_STATES extra busy cycles per access.
// Ports:
//   clk    system clock, all state on rising edge
//   reset  synchronous active-high reset
//   dmem   rv32e_dmem_responder_if.slave (request in, data/ready/error out)
// Optional feature: define DMEM_ERR_CHECK_EN to reject illegal byte-enable
// patterns, read+write collisions and out-of-window addresses with dmem_error.
// Without it, any access is honoured and the index wraps mod DEPTH_WORDS.
module rv32e_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32e_dmem_responder_if.slave  dmem
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;       // response updates dmem_data_in (read or error)
  logic [31:0] pend_q, pend_d;     // response word captured at acceptance
  logic [31:0] data_in_q, data_in_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        req, accept, is_write, illegal, mem_we;
  logic [31:0] resp_data;

  assign req      = dmem.dmem_read | dmem.dmem_write;
  assign accept   = !reset && req && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign off      = dmem.dmem_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  // read&write together resolves as a write when checks are off
  assign is_write = dmem.dmem_write;

`ifdef DMEM_ERR_CHECK_EN
  logic be_ok;
  logic in_range;

  always_comb begin
    be_ok = 1'b0;
    case (dmem.dmem_byte_enable)
      4'b0001: be_ok = (dmem.dmem_addr[1:0] == 2'd0);
      4'b0010: be_ok = (dmem.dmem_addr[1:0] == 2'd1);
      4'b0100: be_ok = (dmem.dmem_addr[1:0] == 2'd2);
      4'b1000: be_ok = (dmem.dmem_addr[1:0] == 2'd3);
      4'b0011: be_ok = (dmem.dmem_addr[1:0] == 2'd0);
      4'b1100: be_ok = (dmem.dmem_addr[1:0] == 2'd2);
      4'b1111: be_ok = (dmem.dmem_addr[1:0] == 2'd0);
      default: be_ok = 1'b0;
    endcase
  end

  // BASE_ADDR is window-aligned, so the wrapped offset is in range iff its
  // bits above the window are all zero.
  assign in_range = (off[31:AW+2] == '0);
  assign illegal  = !be_ok || (dmem.dmem_read && dmem.dmem_write) || !in_range;
`else
  logic unused_off;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
  assign illegal    = 1'b0;
`endif

  assign mem_we    = accept && is_write && !illegal;
  assign resp_data = illegal ? 32'd0 : mem_q[idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    upd_d     = upd_q;
    pend_d    = pend_q;
    data_in_d = data_in_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
          if (upd_q) data_in_d = pend_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          err_d = illegal;
          upd_d = illegal || !is_write;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            if (illegal || !is_write) data_in_d = resp_data;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
            pend_d  = resp_data;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      err_q     <= 1'b0;
      upd_q     <= 1'b0;
      pend_q    <= 32'd0;
      data_in_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      pend_q    <= pend_d;
      data_in_q <= data_in_d;
    end
  end

  // RAM is not reset; writes commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (dmem.dmem_byte_enable[k]) mem_q[idx][8*k +: 8] <= dmem.dmem_data_out[8*k +: 8];
      end
    end
  end

  assign dmem.dmem_data_in = data_in_q;
  assign dmem.dmem_ready   = (state_q == ST_RESP);
  assign dmem.dmem_error   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_rv32e_dmem_responder.sv
module tb_rv32e_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rv32e_dmem_responder_if bus0 ();
  rv32e_dmem_responder_if bus1 ();
  rv32e_dmem_responder_if bus2 ();

  rv32e_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .dmem(bus0.slave));
  rv32e_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .dmem(bus1.slave));
  rv32e_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .dmem(bus2.slave));

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model0 [DEPTH];
  logic [31:0] last_rd0 = 32'd0;
  logic        prev_req0 = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic bit model_legal(input logic r, input logic w, input logic [31:0] a,
                                     input logic [3:0] be);
`ifdef DMEM_ERR_CHECK_EN
    logic [31:0] off;
    logic [1:0]  lo;
    logic [3:0]  one;
    off = a - BASE;
    lo  = a[1:0];
    one = 4'b0001 << lo;
    if (r && w) return 1'b0;
    if (off >= DEPTH * 4) return 1'b0;
    return (be == one) || (be == 4'b0011 && lo == 2'd0) || (be == 4'b1100 && lo == 2'd2) ||
           (be == 4'b1111 && lo == 2'd0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_push0(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    exp_t        e;
    int unsigned ix;
    ix = ((a - BASE) >> 2) % DEPTH;
    if (!model_legal(r, w, a, be)) begin
      e.data = 32'd0; e.err = 1'b1; last_rd0 = 32'd0;
    end else if (w) begin
      for (int k = 0; k < 4; k++) if (be[k]) model0[ix][8*k +: 8] = d[8*k +: 8];
      e.data = last_rd0; e.err = 1'b0;
    end else begin
      e.data = model0[ix]; e.err = 1'b0; last_rd0 = model0[ix];
    end
    sb_q.push_back(e);
  endtask

  // One cycle on dut0: check this cycle's response, then drive the next request.
  task automatic cycle0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    @(negedge clk);
    checks++;
    if (bus0.dmem_ready !== prev_req0) begin
      errors++;
      $display("FAIL ready0_timing: got %b want %b at %0t", bus0.dmem_ready, prev_req0, $time);
    end
    if (bus0.dmem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: unexpected ready at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (bus0.dmem_data_in !== e.data) begin
          errors++;
          $display("FAIL rdata0: got %h want %h at %0t", bus0.dmem_data_in, e.data, $time);
        end
        checks++;
        if (bus0.dmem_error !== e.err) begin
          errors++;
          $display("FAIL error0: got %b want %b at %0t", bus0.dmem_error, e.err, $time);
        end
      end
    end
    bus0.dmem_read = r; bus0.dmem_write = w; bus0.dmem_addr = a;
    bus0.dmem_data_out = d; bus0.dmem_byte_enable = be;
    prev_req0 = r | w;
    if (r | w) model_push0(r, w, a, d, be);
  endtask

  task automatic drain0();
    cycle0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    cycle0(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses missing, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic acc1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit garble,
                      output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    bus1.dmem_read = r; bus1.dmem_write = w; bus1.dmem_addr = a;
    bus1.dmem_data_out = d; bus1.dmem_byte_enable = be;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus1.dmem_ready === 1'b1) begin
        rd = bus1.dmem_data_in; e = bus1.dmem_error; lat = i;
        break;
      end
      if (garble) begin
        bus1.dmem_read = 1'b0; bus1.dmem_write = 1'b1; bus1.dmem_addr = 32'h10;
        bus1.dmem_data_out = 32'hFFFF_FFFF; bus1.dmem_byte_enable = 4'hF;
      end
    end
    bus1.dmem_read = 1'b0; bus1.dmem_write = 1'b0;
  endtask

  task automatic acc2(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output int lat);
    @(negedge clk);
    bus2.dmem_read = r; bus2.dmem_write = w; bus2.dmem_addr = a;
    bus2.dmem_data_out = d; bus2.dmem_byte_enable = be;
    lat = -1; rd = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus2.dmem_ready === 1'b1) begin
        rd = bus2.dmem_data_in; lat = i;
        break;
      end
    end
    bus2.dmem_read = 1'b0; bus2.dmem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.dmem_ready !== 1'b0 || bus0.dmem_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags0: ready=%b error=%b want 0 0", bus0.dmem_ready, bus0.dmem_error);
    end
    checks++;
    if (bus0.dmem_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_data0: got %h want 0", bus0.dmem_data_in);
    end
    checks++;
    if (bus1.dmem_ready !== 1'b0 || bus2.dmem_ready !== 1'b0 || bus1.dmem_data_in !== 32'd0 ||
        bus2.dmem_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_waitduts: ready1=%b ready2=%b d1=%h d2=%h want 0",
               bus1.dmem_ready, bus2.dmem_ready, bus1.dmem_data_in, bus2.dmem_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    cycle0(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    cycle0(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    drain0();
    checks++;
    if (bus0.dmem_data_in !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read_hold: got %h want deadbeef", bus0.dmem_data_in);
    end
  endtask

  task automatic test_byte_merge();
    cycle0(1'b0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
    cycle0(1'b0, 1'b1, 32'h13, 32'hBB00_0000, 4'b1000);
    cycle0(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    drain0();
    checks++;
    if (bus0.dmem_data_in !== 32'hBBAD_BEAA) begin
      errors++;
      $display("FAIL byte_merge: got %h want bbadbeaa", bus0.dmem_data_in);
    end
  endtask

  task automatic test_back_to_back();
    cycle0(1'b0, 1'b1, 32'h0, 32'h0102_0304, 4'hF);
    cycle0(1'b0, 1'b1, 32'h4, 32'h0A0B_0C0D, 4'hF);
    cycle0(1'b0, 1'b1, 32'h8, 32'h1111_2222, 4'hF);
    cycle0(1'b1, 1'b0, 32'h0, 32'd0, 4'hF);
    cycle0(1'b1, 1'b0, 32'h4, 32'd0, 4'hF);
    cycle0(1'b1, 1'b0, 32'h8, 32'd0, 4'hF);
    drain0();
  endtask

  task automatic test_error();
    logic [31:0] want;
    cycle0(1'b0, 1'b1, 32'h12, 32'hDEAD_DEAD, 4'hF);
    cycle0(1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    cycle0(1'b1, 1'b0, 32'h10, 32'd0, 4'b0101);
    cycle0(1'b1, 1'b1, 32'h8, 32'h7777_8888, 4'hF);
    cycle0(1'b1, 1'b0, 32'h8, 32'd0, 4'hF);
    cycle0(1'b1, 1'b0, BASE + DEPTH * 4, 32'd0, 4'hF);
    drain0();
`ifdef DMEM_ERR_CHECK_EN
    want = 32'd0;
`else
    want = 32'h0102_0304;
`endif
    checks++;
    if (bus0.dmem_data_in !== want) begin
      errors++;
      $display("FAIL out_of_range_read: got %h want %h", bus0.dmem_data_in, want);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        e;
    int          lat;
    acc1(1'b0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 1'b0, rd, e, lat);
    checks++;
    if (lat != 4 || e !== 1'b0) begin
      errors++;
      $display("FAIL wait3_write: latency %0d error %b want 4 0", lat, e);
    end
    acc1(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b1, rd, e, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL wait3_read_latency: got %0d want 4", lat);
    end
    checks++;
    if (rd !== 32'hA5A5_1234 || e !== 1'b0) begin
      errors++;
      $display("FAIL wait3_read_data: got %h err %b want a5a51234 0", rd, e);
    end
    @(negedge clk);
    checks++;
    if (bus1.dmem_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait3_pulse: ready %b want 0 after response", bus1.dmem_ready);
    end
    acc1(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, rd, e, lat);
    checks++;
    if (rd !== 32'hA5A5_1234) begin
      errors++;
      $display("FAIL wait3_ignored_write: got %h want a5a51234", rd);
    end
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] rd;
    int          lat;
    bit          seen;
    acc2(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, rd, lat);
    acc2(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, rd, lat);
    checks++;
    if (lat != 3 || rd !== 32'h1122_3344) begin
      errors++;
      $display("FAIL wait2_read: latency %0d data %h want 3 11223344", lat, rd);
    end
    @(negedge clk);
    bus2.dmem_write = 1'b1; bus2.dmem_addr = 32'h10;
    bus2.dmem_data_out = 32'hCAFE_F00D; bus2.dmem_byte_enable = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    bus2.dmem_write = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.dmem_ready !== 1'b0 || bus2.dmem_error !== 1'b0 || bus2.dmem_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_wait: ready=%b error=%b data=%h want 0 0 0",
               bus2.dmem_ready, bus2.dmem_error, bus2.dmem_data_in);
    end
    checks++;
    if (bus0.dmem_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_data0_again: got %h want 0", bus0.dmem_data_in);
    end
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus2.dmem_ready === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abandoned_ready: got ready pulse want none");
    end
    acc2(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, rd, lat);
    checks++;
    if (lat != 3 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL committed_write: latency %0d data %h want 3 cafef00d", lat, rd);
    end
  endtask

  initial begin
    bus0.dmem_read = 1'b0; bus0.dmem_write = 1'b0; bus0.dmem_addr = 32'd0;
    bus0.dmem_data_out = 32'd0; bus0.dmem_byte_enable = 4'd0;
    bus1.dmem_read = 1'b0; bus1.dmem_write = 1'b0; bus1.dmem_addr = 32'd0;
    bus1.dmem_data_out = 32'd0; bus1.dmem_byte_enable = 4'd0;
    bus2.dmem_read = 1'b0; bus2.dmem_write = 1'b0; bus2.dmem_addr = 32'd0;
    bus2.dmem_data_out = 32'd0; bus2.dmem_byte_enable = 4'd0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_back_to_back();
    test_error();
    test_wait_states();
    test_reset_during_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
